vga_timing_gen: RTL and testbench

//  Consumes the one-clk-wide pixel-enable strobe from the pixel clock divider.

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v sync, data-enable and pixel coordinates, advanced by a pixel-enable strobe.
// Optional pixel-strobe watchdog enabled by defining VTG_PCLK_WDOG_EN.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int WDOG_LIMIT = 16,
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP,
   localparam int XW        = $clog2(H_TOTAL),
   localparam int YW        = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pclk_en,
   output logic          h_sync,
   output logic          v_sync,
   output logic          de,
   output logic [XW-1:0] x_pixel,
   output logic [YW-1:0] y_pixel,
   output logic          line_start,
   output logic          frame_start,
   output logic          pclk_lost
);

   localparam logic          SYNC_ON   = (SYNC_POL != 0);
   localparam logic [XW-1:0] H_ACT_END = XW'(H_VISIBLE - 1);
   localparam logic [XW-1:0] H_FP_END  = XW'(H_VISIBLE + H_FP - 1);
   localparam logic [XW-1:0] H_SYN_END = XW'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_ACT_END = YW'(V_VISIBLE - 1);
   localparam logic [YW-1:0] V_FP_END  = YW'(V_VISIBLE + V_FP - 1);
   localparam logic [YW-1:0] V_SYN_END = YW'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);

   typedef enum logic [1:0] {ST_H_ACT, ST_H_FP, ST_H_SYN, ST_H_BP} h_state_t;
   typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYN, ST_V_BP} v_state_t;

   h_state_t        r_h_state;
   v_state_t        r_v_state;
   logic [XW-1:0]   r_h_cnt;
   logic [YW-1:0]   r_v_cnt;
   logic            w_h_last;

   assign w_h_last = (r_h_cnt == H_LAST);

   // Outputs present the position held before the tick; counters and phases then advance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_state   <= ST_H_ACT;
         r_v_state   <= ST_V_ACT;
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         h_sync      <= ~SYNC_ON;
         v_sync      <= ~SYNC_ON;
         de          <= 1'b0;
         x_pixel     <= '0;
         y_pixel     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pclk_en) begin
         de          <= (r_h_state == ST_H_ACT) && (r_v_state == ST_V_ACT);
         h_sync      <= (r_h_state == ST_H_SYN) ? SYNC_ON : ~SYNC_ON;
         v_sync      <= (r_v_state == ST_V_SYN) ? SYNC_ON : ~SYNC_ON;
         x_pixel     <= r_h_cnt;
         y_pixel     <= r_v_cnt;
         line_start  <= (r_h_cnt == '0);
         frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);

         r_h_cnt <= w_h_last ? '0 : r_h_cnt + XW'(1);
         case (r_h_state)
            ST_H_ACT: if (r_h_cnt == H_ACT_END) r_h_state <= ST_H_FP;
            ST_H_FP:  if (r_h_cnt == H_FP_END)  r_h_state <= ST_H_SYN;
            ST_H_SYN: if (r_h_cnt == H_SYN_END) r_h_state <= ST_H_BP;
            default:  if (w_h_last)             r_h_state <= ST_H_ACT;
         endcase

         if (w_h_last) begin
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + YW'(1);
            case (r_v_state)
               ST_V_ACT: if (r_v_cnt == V_ACT_END) r_v_state <= ST_V_FP;
               ST_V_FP:  if (r_v_cnt == V_FP_END)  r_v_state <= ST_V_SYN;
               ST_V_SYN: if (r_v_cnt == V_SYN_END) r_v_state <= ST_V_BP;
               default:  if (r_v_cnt == V_LAST)    r_v_state <= ST_V_ACT;
            endcase
         end
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

`ifdef VTG_PCLK_WDOG_EN
   localparam int WW = $clog2(WDOG_LIMIT + 1);

   logic [WW-1:0] r_wdog_cnt;
   logic          r_pclk_lost;

   // Counts clk cycles since the last strobe; the lost flag is sticky until reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wdog_cnt  <= '0;
         r_pclk_lost <= 1'b0;
      end else if (pclk_en) begin
         r_wdog_cnt  <= '0;
      end else begin
         if (r_wdog_cnt != WW'(WDOG_LIMIT)) r_wdog_cnt <= r_wdog_cnt + WW'(1);
         if (r_wdog_cnt == WW'(WDOG_LIMIT - 1)) r_pclk_lost <= 1'b1;
      end
   end

   assign pclk_lost = r_pclk_lost;
`else
   // Watchdog compiled out; the limit is always positive, so this is constant 0.
   assign pclk_lost = (WDOG_LIMIT < 0);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a reduced-raster instance share clock, reset and strobe.
// Per-cycle comparison against a tick-count model, plus literal checkpoints; honours VTG_PCLK_WDOG_EN.
module tb_vga_timing_gen;

   localparam int WDOG = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pclk_en = 1'b0;

   always #5 clk = ~clk;

   logic       hs_d, vs_d, de_d, ls_d, fs_d, lost_d;
   logic [9:0] x_d, y_d;
   logic       hs_s, vs_s, de_s, ls_s, fs_s, lost_s;
   logic [3:0] x_s, y_s;

   vga_timing_gen dut_d (
      .clk(clk), .reset_n(reset_n), .pclk_en(pclk_en),
      .h_sync(hs_d), .v_sync(vs_d), .de(de_d), .x_pixel(x_d), .y_pixel(y_d),
      .line_start(ls_d), .frame_start(fs_d), .pclk_lost(lost_d));

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .clk(clk), .reset_n(reset_n), .pclk_en(pclk_en),
      .h_sync(hs_s), .v_sync(vs_s), .de(de_s), .x_pixel(x_s), .y_pixel(y_s),
      .line_start(ls_s), .frame_start(fs_s), .pclk_lost(lost_s));

   typedef struct packed {
      logic        hs, vs, de, ls, fs, lost;
      logic [15:0] x, y;
   } exp_t;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model state: ticks since reset release, strobe seen at last edge, strobe-free clk run.
   longint m_n;
   bit     m_tk;
   int     m_idle;
   bit     m_lost;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_n <= 0; m_tk <= 0; m_idle <= 0; m_lost <= 0;
      end else begin
         m_tk <= pclk_en;
         if (pclk_en) begin
            m_n    <= m_n + 1;
            m_idle <= 0;
         end else begin
            m_idle <= m_idle + 1;
`ifdef VTG_PCLK_WDOG_EN
            if (m_idle + 1 >= WDOG) m_lost <= 1'b1;
`endif
         end
      end
   end

   // Tick n (1-based) presents raster position n-1 in scan order.
   function automatic exp_t model(longint n, bit tk, bit lost,
                                  int hv, int hfp, int hsw, int hbp,
                                  int vv, int vfp, int vsw, int vbp);
      exp_t   e;
      longint p;
      int     ht, vt, x, y;
      ht = hv + hfp + hsw + hbp;
      vt = vv + vfp + vsw + vbp;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.lost = lost;
      if (n > 0) begin
         p = n - 1;
         x = int'(p % ht);
         y = int'((p / ht) % vt);
         e.x  = 16'(x);
         e.y  = 16'(y);
         e.de = (x < hv) && (y < vv);
         e.hs = !((x >= hv + hfp) && (x < hv + hfp + hsw));
         e.vs = !((y >= vv + vfp) && (y < vv + vfp + vsw));
         e.ls = tk && (x == 0);
         e.fs = tk && (x == 0) && (y == 0);
      end
      return e;
   endfunction

   task automatic cmp_vec(string name, exp_t a, exp_t e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b lost=%0b, want hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b lost=%0b",
                  name, cyc, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.lost,
                  e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.lost);
      end
   endtask

   task automatic chk(string name, longint act, longint req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t a;
      a = '{hs: hs_d, vs: vs_d, de: de_d, ls: ls_d, fs: fs_d, lost: lost_d, x: 16'(x_d), y: 16'(y_d)};
      cmp_vec("full", a, model(m_n, m_tk, m_lost, 640, 16, 96, 48, 480, 10, 2, 33));
      a = '{hs: hs_s, vs: vs_s, de: de_s, ls: ls_s, fs: fs_s, lost: lost_s, x: 16'(x_s), y: 16'(y_s)};
      cmp_vec("small", a, model(m_n, m_tk, m_lost, 8, 2, 3, 3, 6, 2, 2, 2));
   end

   int nt = 0;

   task automatic tick_edge();
      pclk_en = 1'b1;
      @(posedge clk); #1;
      pclk_en = 1'b0;
      nt++;
   endtask

   task automatic idle(int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   // Leaves just after the edge of tick number target, so pulses are visible.
   task automatic goto_tick(longint target, int div);
      while (nt < target) begin
         tick_edge();
         if (nt < target) idle(div - 1);
      end
   endtask

   int c_a, c_b;
   bit exp_lost;

   initial begin
`ifdef VTG_PCLK_WDOG_EN
      exp_lost = 1'b1;
`else
      exp_lost = 1'b0;
`endif
      idle(3);
      chk("rst_de", de_d, 0);     chk("rst_x", x_d, 0);       chk("rst_y", y_d, 0);
      chk("rst_hs", hs_d, 1);     chk("rst_vs", vs_d, 1);
      chk("rst_ls", ls_d, 0);     chk("rst_fs", fs_d, 0);     chk("rst_lost", lost_d, 0);

      // Strobe every 4th clk.
      reset_n = 1'b1;
      goto_tick(1, 4);
      chk("t1_de", de_d, 1); chk("t1_x", x_d, 0); chk("t1_y", y_d, 0);
      chk("t1_fs", fs_d, 1); chk("t1_ls", ls_d, 1); chk("t1_fs_s", fs_s, 1);
      c_a = cyc;
      idle(1);
      chk("t1_fs_drop", fs_d, 0); chk("t1_ls_drop", ls_d, 0); chk("t1_de_hold", de_d, 1);
      idle(2);
      goto_tick(128, 4); chk("s_y7_vs", vs_s, 1); chk("s_y7", y_s, 7); idle(3);
      goto_tick(129, 4); chk("s_y8_vs", vs_s, 0); idle(3);
      goto_tick(160, 4); chk("s_y9_vs", vs_s, 0); idle(3);
      goto_tick(161, 4); chk("s_y10_vs", vs_s, 1); idle(3);
      goto_tick(193, 4); chk("s_fs2", fs_s, 1); chk("s_frame_clks", cyc - c_a, 768); idle(3);
      goto_tick(640, 4); chk("x639_de", de_d, 1); chk("x639", x_d, 639); idle(3);
      goto_tick(641, 4); chk("x640_de", de_d, 0); idle(3);
      goto_tick(656, 4); chk("x655_hs", hs_d, 1); idle(3);
      goto_tick(657, 4); chk("x656_hs", hs_d, 0); idle(3);
      goto_tick(752, 4); chk("x751_hs", hs_d, 0); idle(3);
      goto_tick(753, 4); chk("x752_hs", hs_d, 1); idle(3);
      goto_tick(800, 4); chk("x799", x_d, 799); chk("x799_y", y_d, 0); idle(3);
      goto_tick(801, 4); chk("l1_ls", ls_d, 1); chk("l1_y", y_d, 1); chk("l1_x", x_d, 0);
      chk("line_clks", cyc - c_a, 3200); idle(3);

      // Strobe held high: every clk is a tick.
      goto_tick(961, 1);  c_a = cyc; chk("h_fs_a", fs_s, 1);
      goto_tick(1153, 1); c_b = cyc; chk("h_fs_b", fs_s, 1); chk("h_frame_clks", c_b - c_a, 192);
      goto_tick(1601, 1); c_a = cyc; chk("h_ls_a", ls_d, 1);
      goto_tick(2401, 1); c_b = cyc; chk("h_ls_b", ls_d, 1); chk("h_line_clks", c_b - c_a, 800);

      // Asynchronous reset in the middle of a visible line.
      goto_tick(2701, 1);
      chk("pre_x", x_d, 300); chk("pre_y", y_d, 3); chk("pre_de", de_d, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_x", x_d, 0); chk("ar_y", y_d, 0); chk("ar_de", de_d, 0);
      chk("ar_hs", hs_d, 1); chk("ar_x_s", x_s, 0); chk("ar_y_s", y_s, 0);
      nt = 0;
      @(posedge clk); #1;
      idle(1);
      reset_n = 1'b1;
      goto_tick(1, 2);
      chk("rs_fs", fs_d, 1); chk("rs_ls", ls_d, 1); chk("rs_x", x_d, 0); chk("rs_y", y_d, 0);
      chk("rs_de", de_d, 1);
      idle(1);
      goto_tick(60, 2); chk("rs_x59", x_d, 59); idle(1);

      // Strobe stall.
      idle(WDOG + 4);
      chk("wd_lost", lost_d, longint'(exp_lost));
      chk("wd_x_hold", x_d, 59);
      goto_tick(80, 4); chk("wd_sticky", lost_d, longint'(exp_lost)); chk("wd_x", x_d, 79);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
